// File: rtl/dbgnoc_to_dii_conv_if.sv
// Bus bundle between the dbgnoc virtual-channel side and the DII ring side
// of the dbgnoc-to-DII converter. The converter uses the master modport;
// the environment (sources and DII sink) uses the slave modport.
interface dbgnoc_to_dii_conv_if #(
  parameter int NUM_VC = 2
);

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit_t;

  logic [16:0]       dbgnoc_out_flit;   // {last, data[15:0]}, shared by all VCs
  logic [NUM_VC-1:0] dbgnoc_out_valid;
  logic [NUM_VC-1:0] dbgnoc_out_ready;
  dii_flit_t         debug_out;
  logic              debug_out_ready;

  modport master (
    input  dbgnoc_out_flit,
    input  dbgnoc_out_valid,
    input  debug_out_ready,
    output dbgnoc_out_ready,
    output debug_out
  );

  modport slave (
    output dbgnoc_out_flit,
    output dbgnoc_out_valid,
    output debug_out_ready,
    input  dbgnoc_out_ready,
    input  debug_out
  );

endinterface

// File: rtl/dbgnoc_to_dii_conv.sv
// Merges NUM_VC dbgnoc virtual channels into one DII flit stream.
// A VC is picked round-robin while IDLE, then stays locked until its packet
// ends (last flit, or truncation at MAX_PKT_LEN flits). The DII output is a
// single register stage that can drain and reload in the same cycle.
module dbgnoc_to_dii_conv #(
  parameter int NUM_VC      = 2,
  parameter int MAX_PKT_LEN = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  dbgnoc_to_dii_conv_if.master bus,
  output logic                 err_overrun_o
);

  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // State registers
  state_e          state_q;
  logic [VCW-1:0]  grant_q;
  logic [VCW-1:0]  rr_ptr_q;
  logic [7:0]      cnt_q;
  logic            out_valid_q;
  logic            out_last_q;
  logic [15:0]     out_data_q;
  logic            err_q;

  // Combinational helpers
  logic [VCW-1:0]    arb_sel_s;
  int                best_off_s;
  logic              any_valid_s;
  logic [NUM_VC-1:0] lock_sel_s;
  logic              out_free_s;
  logic              accept_s;
  logic              at_max_s;
  logic              flit_last_s;
  logic              pkt_end_s;
  logic              trunc_s;
  logic [VCW-1:0]    grant_inc_s;

  assign any_valid_s = |bus.dbgnoc_out_valid;
  assign flit_last_s = bus.dbgnoc_out_flit[16];

  // Round-robin pick: the valid VC with the smallest forward distance from rr_ptr.
  always_comb begin
    arb_sel_s  = '0;
    best_off_s = NUM_VC;
    for (int j = 0; j < NUM_VC; j++) begin
      if (bus.dbgnoc_out_valid[j] &&
          (((j - int'(rr_ptr_q) + NUM_VC) % NUM_VC) < best_off_s)) begin
        best_off_s = (j - int'(rr_ptr_q) + NUM_VC) % NUM_VC;
        arb_sel_s  = VCW'(j);
      end else begin
        best_off_s = best_off_s;
      end
    end
  end

  // One-hot of the locked VC; all zero while IDLE so nothing is taken in the grant cycle.
  always_comb begin
    lock_sel_s = '0;
    for (int j = 0; j < NUM_VC; j++) begin
      if ((state_q == LOCKED) && (grant_q == VCW'(j))) begin
        lock_sel_s[j] = 1'b1;
      end else begin
        lock_sel_s[j] = 1'b0;
      end
    end
  end

  // The output register can take a flit when empty or when it drains this cycle.
  assign out_free_s           = !out_valid_q || bus.debug_out_ready;
  assign bus.dbgnoc_out_ready = lock_sel_s & {NUM_VC{out_free_s}};
  assign accept_s             = |(lock_sel_s & bus.dbgnoc_out_valid) && out_free_s;

  // Packet end: real last flit, or the MAX_PKT_LEN-th flit which gets last forced.
  assign at_max_s    = (cnt_q == 8'(MAX_PKT_LEN - 1));
  assign pkt_end_s   = flit_last_s || at_max_s;
  assign trunc_s     = at_max_s && !flit_last_s;
  assign grant_inc_s = (grant_q == VCW'(NUM_VC - 1)) ? '0 : (grant_q + 1'b1);

  // Arbitration FSM, flit counter, DII output register and sticky overrun flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 16'h0000;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid_s) begin
            state_q <= LOCKED;
            grant_q <= arb_sel_s;
            cnt_q   <= 8'd0;
          end
        end
        LOCKED: begin
          // Stay on the granted VC even if it drops valid mid-packet.
          if (accept_s) begin
            cnt_q <= cnt_q + 8'd1;
            if (pkt_end_s) begin
              state_q  <= IDLE;
              rr_ptr_q <= grant_inc_s;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      if (accept_s) begin
        out_valid_q <= 1'b1;
        out_last_q  <= pkt_end_s;
        out_data_q  <= bus.dbgnoc_out_flit[15:0];
      end else if (bus.debug_out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept_s && trunc_s) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.debug_out  = {out_valid_q, out_last_q, out_data_q};
  assign err_overrun_o  = err_q;

endmodule

// File: tb/tb_dbgnoc_to_dii_conv.sv
// Directed, table-driven bench for dbgnoc_to_dii_conv (NUM_VC=2, MAX_PKT_LEN=4).
// Each vector drives inputs on the falling edge, then checks the combinational
// ready bits and the registered outputs just after, before the next rising edge.
module tb_dbgnoc_to_dii_conv;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;

  dbgnoc_to_dii_conv_if #(.NUM_VC(2)) bus ();

  dbgnoc_to_dii_conv #(
    .NUM_VC      (2),
    .MAX_PKT_LEN (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .bus           (bus),
    .err_overrun_o (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic        lst;
    logic [15:0] dat;
    logic        rdy;
    logic [1:0]  e_rdy;
    logic        e_v;
    logic        e_l;
    logic [15:0] e_d;
    logic        e_err;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  function automatic vec_t mkv(input logic r, input logic [1:0] vl, input logic l,
                               input logic [15:0] d, input logic rd,
                               input logic [1:0] er, input logic ev, input logic el,
                               input logic [15:0] ed, input logic ee);
    vec_t v;
    v.rst = r;  v.vld = vl; v.lst = l;  v.dat = d;  v.rdy = rd;
    v.e_rdy = er; v.e_v = ev; v.e_l = el; v.e_d = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    logic ok;
    @(negedge clk);
    rst                  = v.rst;
    bus.dbgnoc_out_valid = v.vld;
    bus.dbgnoc_out_flit  = {v.lst, v.dat};
    bus.debug_out_ready  = v.rdy;
    #1;
    ok = (bus.dbgnoc_out_ready === v.e_rdy) && (bus.debug_out.valid === v.e_v) &&
         (err === v.e_err);
    if (v.e_v) begin
      ok = ok && (bus.debug_out.last === v.e_l) && (bus.debug_out.data === v.e_d);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got rdy=%b v=%b l=%b d=%h err=%b, expected rdy=%b v=%b l=%b d=%h err=%b",
               nm, bus.dbgnoc_out_ready, bus.debug_out.valid, bus.debug_out.last,
               bus.debug_out.data, err, v.e_rdy, v.e_v, v.e_l, v.e_d, v.e_err);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst                  = 1'b1;
    bus.dbgnoc_out_valid = 2'b00;
    bus.dbgnoc_out_flit  = 17'h00000;
    bus.debug_out_ready  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ((bus.dbgnoc_out_ready !== 2'b00) || (bus.debug_out !== 18'h00000) || (err !== 1'b0)) begin
      failures++;
      $display("FAIL %s: got rdy=%b debug_out=%h err=%b, expected rdy=00 debug_out=00000 err=0",
               nm, bus.dbgnoc_out_ready, bus.debug_out, err);
    end
  endtask

  initial begin
    bus.dbgnoc_out_valid = 2'b00;
    bus.dbgnoc_out_flit  = 17'h00000;
    bus.debug_out_ready  = 1'b0;

    // 3-flit VC0 packet, then 4-flit VC0 packet under ready 1,0,0,1,1, then a VC1 packet.
    //                r     vld   l     dat        rdy   e_rdy  ev    el    e_d        err
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'h1111, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'h1111, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'h2222, 1'b1, 2'b01, 1'b1, 1'b0, 16'h1111, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b1, 16'h3333, 1'b1, 2'b01, 1'b1, 1'b0, 16'h2222, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'h3333, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'hA001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'hA001, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'hA002, 1'b0, 2'b00, 1'b1, 1'b0, 16'hA001, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'hA002, 1'b0, 2'b00, 1'b1, 1'b0, 16'hA001, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'hA002, 1'b1, 2'b01, 1'b1, 1'b0, 16'hA001, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b0, 16'hA003, 1'b1, 2'b01, 1'b1, 1'b0, 16'hA002, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b01, 1'b1, 16'hA004, 1'b1, 2'b01, 1'b1, 1'b0, 16'hA003, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'hA004, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b11, 1'b1, 16'hB001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b11, 1'b1, 16'hB001, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'hB001, 1'b0));
    tbl.push_back(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0));

    do_reset("reset_state_0");
    foreach (tbl[i]) begin
      run_vec(tbl[i], $sformatf("table_row_%0d", i));
    end

    // Both VCs hold 2-flit packets from reset: VC0, VC1, VC0, never interleaved.
    do_reset("reset_state_1");
    run_vec(mkv(1'b0, 2'b11, 1'b0, 16'h0A01, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0), "rr_s0");
    run_vec(mkv(1'b0, 2'b11, 1'b0, 16'h0A01, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0), "rr_s1");
    run_vec(mkv(1'b0, 2'b11, 1'b1, 16'h0A02, 1'b1, 2'b01, 1'b1, 1'b0, 16'h0A01, 1'b0), "rr_s2");
    run_vec(mkv(1'b0, 2'b11, 1'b0, 16'h0B01, 1'b1, 2'b00, 1'b1, 1'b1, 16'h0A02, 1'b0), "rr_s3");
    run_vec(mkv(1'b0, 2'b11, 1'b0, 16'h0B01, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0), "rr_s4");
    run_vec(mkv(1'b0, 2'b11, 1'b1, 16'h0B02, 1'b1, 2'b10, 1'b1, 1'b0, 16'h0B01, 1'b0), "rr_s5");
    run_vec(mkv(1'b0, 2'b11, 1'b0, 16'h0C01, 1'b1, 2'b00, 1'b1, 1'b1, 16'h0B02, 1'b0), "rr_s6");
    run_vec(mkv(1'b0, 2'b11, 1'b0, 16'h0C01, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0), "rr_s7");
    run_vec(mkv(1'b0, 2'b11, 1'b1, 16'h0C02, 1'b1, 2'b01, 1'b1, 1'b0, 16'h0C01, 1'b0), "rr_s8");
    run_vec(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'h0C02, 1'b0), "rr_s9");

    // VC1 sends 6 flits, last only on the sixth: split 4 (forced last) + 2, overrun sticks.
    do_reset("reset_state_2");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0), "ovr_t0");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD001, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0), "ovr_t1");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD002, 1'b1, 2'b10, 1'b1, 1'b0, 16'hD001, 1'b0), "ovr_t2");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD003, 1'b1, 2'b10, 1'b1, 1'b0, 16'hD002, 1'b0), "ovr_t3");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD004, 1'b1, 2'b10, 1'b1, 1'b0, 16'hD003, 1'b0), "ovr_t4");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD005, 1'b1, 2'b00, 1'b1, 1'b1, 16'hD004, 1'b1), "ovr_t5");
    run_vec(mkv(1'b0, 2'b10, 1'b0, 16'hD005, 1'b1, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b1), "ovr_t6");
    run_vec(mkv(1'b0, 2'b10, 1'b1, 16'hD006, 1'b1, 2'b10, 1'b1, 1'b0, 16'hD005, 1'b1), "ovr_t7");
    run_vec(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'hD006, 1'b1), "ovr_t8");
    run_vec(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1), "ovr_t9");

    // VC0 single-flit packet moves rr_ptr to 1, then reset lands mid-packet;
    // afterwards rr_ptr is back at 0 so VC0 wins against VC1.
    run_vec(mkv(1'b0, 2'b01, 1'b1, 16'hF001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b1), "rst_u0");
    run_vec(mkv(1'b0, 2'b01, 1'b1, 16'hF001, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1), "rst_u1");
    run_vec(mkv(1'b0, 2'b01, 1'b0, 16'hE001, 1'b1, 2'b00, 1'b1, 1'b1, 16'hF001, 1'b1), "rst_u2");
    run_vec(mkv(1'b0, 2'b01, 1'b0, 16'hE001, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b1), "rst_u3");
    run_vec(mkv(1'b0, 2'b01, 1'b0, 16'hE002, 1'b1, 2'b01, 1'b1, 1'b0, 16'hE001, 1'b1), "rst_u4");
    run_vec(mkv(1'b1, 2'b01, 1'b0, 16'hE003, 1'b1, 2'b01, 1'b1, 1'b0, 16'hE002, 1'b1), "rst_u5");
    run_vec(mkv(1'b0, 2'b11, 1'b1, 16'h6001, 1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0), "rst_u6");
    run_vec(mkv(1'b0, 2'b11, 1'b1, 16'h6001, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0), "rst_u7");
    run_vec(mkv(1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 1'b1, 16'h6001, 1'b0), "rst_u8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
